// File: rtl/hazard_fwd_unit.sv
// EX-stage hazard unit: operand forwarding, load-use and accelerator stall
// detection, pending-write scoreboard and a saturating stall counter.
module hazard_fwd_unit #(
  parameter int unsigned REG_W   = 3,
  parameter int unsigned R0_ZERO = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exmem_regWrite,
  input  logic             memwb_regWrite,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_regWrite,
  input  logic             idex_memRead,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [REG_W-1:0] ifid_rd,
  input  logic             ifid_regWrite,
  input  logic             acc_issue,
  input  logic [REG_W-1:0] acc_rd,
  input  logic             acc_wb_valid,
  input  logic [REG_W-1:0] acc_wb_rd,
  input  logic             stall_cnt_clr,
  output logic [1:0]       alu_in_1_src,
  output logic [1:0]       alu_in_2_src,
  output logic             stall,
  output logic             flush_idex,
  output logic             sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned NREG = 2 ** REG_W;
  localparam logic [1:0] SEL_EXMEM = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_RF    = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;
  logic            load_use;
  logic            acc_raw;
  logic            issue_raw;
  logic            acc_waw;

  // Register 0 takes part in no hazard when it is hardwired to zero.
  function automatic logic live(input logic [REG_W-1:0] r);
    return (R0_ZERO == 0) || (r != '0);
  endfunction

  always_comb begin
    alu_in_1_src = SEL_RF;
    alu_in_2_src = SEL_RF;
    if (live(idex_rs)) begin
      if (exmem_regWrite && (exmem_rd == idex_rs))      alu_in_1_src = SEL_EXMEM;
      else if (memwb_regWrite && (memwb_rd == idex_rs)) alu_in_1_src = SEL_MEMWB;
    end
    if (live(idex_rt)) begin
      if (exmem_regWrite && (exmem_rd == idex_rt))      alu_in_2_src = SEL_EXMEM;
      else if (memwb_regWrite && (memwb_rd == idex_rt)) alu_in_2_src = SEL_MEMWB;
    end
  end

  always_comb begin
    load_use  = idex_memRead && idex_regWrite && live(idex_rd) &&
                ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    acc_raw   = (live(ifid_rs) && sb[ifid_rs]) || (live(ifid_rt) && sb[ifid_rt]);
    issue_raw = acc_issue && live(acc_rd) &&
                ((acc_rd == ifid_rs) || (acc_rd == ifid_rt));
    acc_waw   = ifid_regWrite && live(ifid_rd) &&
                (sb[ifid_rd] || (acc_issue && (acc_rd == ifid_rd)));
    stall      = load_use || acc_raw || issue_raw || acc_waw;
    flush_idex = stall;
  end

  // Clear first so a same-cycle issue to the same register keeps the bit set.
  always_comb begin
    sb_nxt = sb;
    if (acc_wb_valid) sb_nxt[acc_wb_rd] = 1'b0;
    if (acc_issue)    sb_nxt[acc_rd]    = 1'b1;
    if (R0_ZERO != 0) sb_nxt[0]         = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_nxt;
  end

  assign sb_busy = |sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cnt <= '0;
    else if (stall_cnt_clr)                   stall_cnt <= '0;
    else if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
